// File: rtl/ad9252_pkg.sv
// Shared constants and state encoding for the AD9252 frame/word alignment logic.
package ad9252_pkg;

   localparam int WORD_W = 14;

   localparam logic [WORD_W-1:0] FRAME_PATTERN_DEF = 14'h3F80;
   localparam logic [WORD_W-1:0] TEST_PATTERN_DEF  = 14'h2A3C;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_COMPARE = 3'd2,
      ST_SLIP    = 3'd3,
      ST_ALIGNED = 3'd4,
      ST_FAIL    = 3'd5
   } align_state_e;

endpackage

// File: rtl/ad9252_frame_align_if.sv
// Signal bundle between the alignment controller and its deserializer/config environment.
interface ad9252_frame_align_if;
   import ad9252_pkg::*;

   logic              test_cfg_done;
   logic              realign;
   logic [WORD_W-1:0] frame_word;
   logic [WORD_W-1:0] data_word;
   logic              bitslip;
   logic              data_aligned;
   logic              align_fail;
   logic [3:0]        slip_count;
   logic [2:0]        state_align;

   modport slave (
      input  test_cfg_done, realign, frame_word, data_word,
      output bitslip, data_aligned, align_fail, slip_count, state_align
   );

   modport master (
      output test_cfg_done, realign, frame_word, data_word,
      input  bitslip, data_aligned, align_fail, slip_count, state_align
   );

endinterface

// File: rtl/ad9252_frame_align.sv
// Bitslip-based word alignment for one AD9252 channel: slip the deserializer until
// both the FCO word and the test-pattern data word match for MATCH_COUNT words in a row.
module ad9252_frame_align
   import ad9252_pkg::*;
#(
   parameter logic [WORD_W-1:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
   parameter logic [WORD_W-1:0] TEST_PATTERN  = TEST_PATTERN_DEF,
   parameter int                SETTLE_CYCLES = 16,
   parameter int                MATCH_COUNT   = 8,
   parameter int                MAX_SLIPS     = 14
) (
   input  logic               clk_adc,
   input  logic               reset,
   ad9252_frame_align_if.slave bus
);

   align_state_e state_q, state_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [3:0]   slip_q, slip_d;
   logic         bitslip_q;
   logic         aligned_q;
   logic         fail_q;
   logic         wordMatch;
   logic         abort;

   // One counter serves both the settle wait and the consecutive-match run,
   // since the two phases never overlap.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      slip_d    = slip_q;
      wordMatch = (bus.frame_word == FRAME_PATTERN) && (bus.data_word == TEST_PATTERN);
      abort     = !bus.test_cfg_done &&
                  ((state_q == ST_SETTLE) || (state_q == ST_COMPARE) || (state_q == ST_SLIP));

      if (bus.realign || abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         slip_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d  = '0;
               slip_d = '0;
               if (bus.test_cfg_done) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                  state_d = ST_COMPARE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            ST_COMPARE: begin
               if (wordMatch) begin
                  if (cnt_q == 8'(MATCH_COUNT - 1)) begin
                     state_d = ST_ALIGNED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = (slip_q < 4'(MAX_SLIPS)) ? ST_SLIP : ST_FAIL;
               end
            end
            ST_SLIP: begin
               if (slip_q < 4'(MAX_SLIPS)) slip_d = slip_q + 4'd1;
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
            ST_ALIGNED: state_d = ST_ALIGNED;
            ST_FAIL:    state_d = ST_FAIL;
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               slip_d  = '0;
            end
         endcase
      end
   end

   // Outputs are registered off the next state so they line up exactly with state_q.
   always_ff @(posedge clk_adc or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         slip_q    <= '0;
         bitslip_q <= 1'b0;
         aligned_q <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         slip_q    <= slip_d;
         bitslip_q <= (state_d == ST_SLIP);
         aligned_q <= (state_d == ST_ALIGNED);
         fail_q    <= (state_d == ST_FAIL);
      end
   end

   assign bus.bitslip      = bitslip_q;
   assign bus.data_aligned = aligned_q;
   assign bus.align_fail   = fail_q;
   assign bus.slip_count   = slip_q;
   assign bus.state_align  = state_q;

endmodule

// File: doc/ad9252_frame_align.md
AD9252_FRAME_ALIGN -- requirements
Module: ad9252_frame_align

Interface
REQ-001 Parameter FRAME_PATTERN, default 14'h3F80, expected deserialized FCO word when aligned.
REQ-002 Parameter TEST_PATTERN, default 14'h2A3C, expected data word while the ADC outputs its user test pattern.
REQ-003 Parameter SETTLE_CYCLES, default 16, wait after each bitslip before comparing (1..255).
REQ-004 Parameter MATCH_COUNT, default 8, consecutive matching words required to declare alignment (1..255).
REQ-005 Parameter MAX_SLIPS, default 14, bitslips tried before declaring failure (1..15).
REQ-006 Ports, one clock, asynchronous active-high reset:
  clk_adc        in   1   word-rate clock, all logic on rising edge
  reset          in   1   asynchronous, active-high
  test_cfg_done  in   1   level; high once the ADC test-pattern configuration has been written
  realign        in   1   single-cycle pulse; restarts alignment
  frame_word     in   14  deserialized frame-clock word, one per cycle
  data_word      in   14  deserialized data-channel word, one per cycle
  bitslip        out  1   single-cycle pulse to the deserializer
  data_aligned   out  1   level; alignment achieved
  align_fail     out  1   level; MAX_SLIPS exhausted without alignment
  slip_count     out  4   bitslips issued in the current attempt
  state_align    out  3   current state encoding, for debug

Function
REQ-007 States: IDLE=0, SETTLE=1, COMPARE=2, SLIP=3, ALIGNED=4, FAIL=5.
REQ-008 IDLE -> SETTLE when test_cfg_done=1; slip_count and counters cleared on entry to SETTLE from IDLE.
REQ-009 SETTLE: counter runs for exactly SETTLE_CYCLES cycles, then -> COMPARE; inputs ignored.
REQ-010 COMPARE: a word matches when frame_word==FRAME_PATTERN and data_word==TEST_PATTERN in the same cycle.
REQ-011 COMPARE: each match increments match counter; on MATCH_COUNT-th consecutive match -> ALIGNED next cycle.
REQ-012 COMPARE: any mismatch -> SLIP if slip_count<MAX_SLIPS, else -> FAIL; match counter cleared.
REQ-013 SLIP: bitslip=1 for exactly one cycle, slip_count increments, -> SETTLE.
REQ-014 bitslip is registered and asserted only in SLIP; never two pulses closer than SETTLE_CYCLES+2 cycles.
REQ-015 ALIGNED: data_aligned=1, held until reset or realign; inputs no longer checked.
REQ-016 FAIL: align_fail=1, held until reset or realign; no further bitslip.
REQ-017 realign=1 in any state -> IDLE next cycle, clears data_aligned, align_fail, slip_count, counters; realign takes priority over all other transitions.
REQ-018 test_cfg_done deasserting in SETTLE/COMPARE/SLIP -> IDLE (abort, counters cleared); ignored in ALIGNED/FAIL.
REQ-019 slip_count saturates at MAX_SLIPS; never wraps.
REQ-020 Alignment after N slips: data_aligned rises exactly (N+1)*SETTLE_CYCLES + 2N + MATCH_COUNT + 1 cycles after leaving IDLE, given clean matches.
REQ-021 data_aligned and align_fail never high simultaneously.

Reset
REQ-022 On reset: state IDLE, bitslip=0, data_aligned=0, align_fail=0, slip_count=0, state_align=0, all counters 0.
REQ-023 Reset asserted mid-attempt terminates it immediately; no bitslip pulse emitted during or on release of reset.

Structure
REQ-024 Shared package ad9252_pkg holds state encoding constants, default FRAME_PATTERN and TEST_PATTERN, word width 14.
REQ-025 Single module, no sub-modules; one FSM, one settle/match counter, one slip counter.

Verification
REQ-026 Inputs already matching from start, defaults -> zero bitslips, data_aligned high 25 cycles after test_cfg_done, slip_count=0.
REQ-027 Model deserializer rotated by 5 bits, rotating one bit per bitslip -> exactly 5 bitslip pulses, then data_aligned=1, slip_count=5.
REQ-028 Inputs never match -> 14 bitslips, then align_fail=1, data_aligned=0, slip_count=14, no 15th pulse.
REQ-029 Single corrupted word at 4th match in COMPARE -> one extra bitslip issued, match counter restarts from 0.
REQ-030 realign pulse while ALIGNED, then test_cfg_done held -> data_aligned drops next cycle, full sequence repeats.
REQ-031 reset asserted during SLIP and test_cfg_done dropped during SETTLE -> all outputs 0 immediately, state_align=0, no bitslip.
